// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared constants for the output FIFO stage
//
// Purpose: default geometry of the output FIFO (column count, partial-sum
// width, per-column depth) and the derived pointer width.
// Ports: none (package).
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH);

endpackage

// File: rtl/ofifo_lane.sv
// rtl/ofifo_lane.sv - single-column first-word-fall-through FIFO lane
//
// Purpose: buffers the partial sums of one array column.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset (pointers, count, overflow)
//   wr       - write strobe; dropped (and overflow set) when full
//   din      - word to write
//   rd       - pop strobe, already qualified by the caller
//   dout     - head word (valid only while not empty)
//   empty    - count == 0
//   full     - count == depth
//   overflow - sticky, set when a write is dropped
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH,
  parameter int ptr_w   = OFIFO_PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               overflow
);

  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  logic [psum_bw-1:0] mem [depth];

  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_wr, do_rd;

  // Flags depend only on the registered count, so the qualified pop that
  // the parent derives from them never loops back into them.
  assign empty    = (count_q == '0);
  assign full     = (count_q == full_cnt);
  assign overflow = overflow_q;
  assign dout     = mem[rd_ptr_q];

  // A full lane refuses the write even when the same edge pops it.
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ptr_w'(do_wr);
    rd_ptr_d   = rd_ptr_q + ptr_w'(do_rd);
    count_d    = count_q + cnt_w'(do_wr) - cnt_w'(do_rd);
    overflow_d = overflow_q | (wr & full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column output FIFO that re-aligns skewed array columns
//
// Purpose: one FWFT lane per array column; a full row is presented only when
// every lane holds at least one word, and all lanes pop together.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in         - packed column psums, lane c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr         - per-column write strobes
//   rd         - pop one row (ignored while o_valid is low)
//   out        - packed head row, zero while o_valid is low
//   o_valid    - every lane non-empty
//   o_full     - some lane full
//   o_ready    - ~o_full
//   o_overflow - sticky, some write was dropped
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [psum_bw*col-1:0] lane_dout;
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_ovf;
  logic                   lane_rd;

  // Every lane sees the same qualified pop so the columns stay row-aligned.
  assign lane_rd = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth),
      .ptr_w   ($clog2(depth))
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr[c]),
      .din      (in[psum_bw*c +: psum_bw]),
      .rd       (lane_rd),
      .dout     (lane_dout[psum_bw*c +: psum_bw]),
      .empty    (lane_empty[c]),
      .full     (lane_full[c]),
      .overflow (lane_ovf[c])
    );
  end

  assign o_valid    = ~|lane_empty;
  assign o_full     = |lane_full;
  assign o_ready    = ~o_full;
  assign o_overflow = |lane_ovf;
  assign out        = o_valid ? lane_dout : '0;

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - self-checking bench for ofifo against a queue model
module tb_ofifo;

  localparam int NC  = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NC*BW-1:0] din = '0;
  logic [NC-1:0]   wr = '0;
  logic            rd = 1'b0;
  logic [NC*BW-1:0] dout;
  logic            o_valid, o_full, o_ready, o_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of words per column plus the sticky flag.
  logic [BW-1:0] mq [NC][$];
  logic          m_ovf = 1'b0;

  ofifo dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .wr         (wr),
    .rd         (rd),
    .out        (dout),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic exp_valid();
    for (int c = 0; c < NC; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_full();
    for (int c = 0; c < NC; c++) if (mq[c].size() == DEP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NC*BW-1:0] exp_out();
    logic [NC*BW-1:0] v;
    v = '0;
    if (exp_valid()) for (int c = 0; c < NC; c++) v[c*BW +: BW] = mq[c][0];
    return v;
  endfunction

  function automatic logic [3:0] exp_st();
    return {exp_valid(), exp_full(), ~exp_full(), m_ovf};
  endfunction

  function automatic logic [NC*BW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_ovf = 1'b0;
  endtask

  // Apply one clock edge to the model using the pre-edge occupancy.
  task automatic model_edge(input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r);
    int pre [NC];
    logic v;
    logic [BW-1:0] junk;
    v = exp_valid();
    for (int c = 0; c < NC; c++) pre[c] = mq[c].size();
    for (int c = 0; c < NC; c++) begin
      if (w[c]) begin
        if (pre[c] == DEP) m_ovf = 1'b1;
        else mq[c].push_back(d[c*BW +: BW]);
      end
    end
    if (r && v) for (int c = 0; c < NC; c++) junk = mq[c].pop_front();
  endtask

  task automatic cycle(input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r);
    wr = w; din = d; rd = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    wr = '0; din = '0; rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NC*BW-1:0] row;
    #1;
    checks++;
    if ({o_valid, o_full, o_ready, o_overflow} !== 4'b0010 || dout !== '0) begin
      errors++;
      $display("FAIL reset_initial: status=%b out=%h required status=0010 out=0",
               {o_valid, o_full, o_ready, o_overflow}, dout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 5; r++) cycle('1, rand_row(), 1'b0);
    checks++;
    if (o_valid !== 1'b1 || dout !== exp_out()) begin
      errors++;
      $display("FAIL reset_prefill: valid=%b out=%h required valid=1 out=%h", o_valid, dout, exp_out());
    end
    // Assert reset between edges; outputs must clear with no clock edge.
    reset = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({o_valid, o_full, o_ready, o_overflow} !== 4'b0010 || dout !== '0) begin
      errors++;
      $display("FAIL reset_async: status=%b out=%h required status=0010 out=0",
               {o_valid, o_full, o_ready, o_overflow}, dout);
    end
    @(negedge clk);
    reset = 1'b1;
    row = rand_row();
    cycle('1, row, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || dout !== row) begin
      errors++;
      $display("FAIL reset_newdata: valid=%b out=%h required valid=1 out=%h", o_valid, dout, row);
    end
    cycle('0, '0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_olddata: valid=%b out=%h required valid=0 out=0", o_valid, dout);
    end
  endtask

  task automatic test_skewed_fill();
    logic [NC*BW-1:0] row;
    do_reset();
    for (int c = 0; c < NC; c++) begin
      row = '0;
      row[c*BW +: BW] = 16'h0100 + 16'(c);
      cycle(NC'(1) << c, row, 1'b0);
      checks++;
      if (o_valid !== (c == NC - 1) || dout !== exp_out()) begin
        errors++;
        $display("FAIL skew_valid c=%0d: valid=%b out=%h required valid=%b out=%h",
                 c, o_valid, dout, (c == NC - 1), exp_out());
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (dout[c*BW +: BW] !== 16'h0100 + 16'(c)) begin
        errors++;
        $display("FAIL skew_lane%0d: got=%h required=%h", c, dout[c*BW +: BW], 16'h0100 + 16'(c));
      end
    end
  endtask

  task automatic test_streaming();
    logic [NC-1:0] w;
    logic [NC*BW-1:0] row;
    int popped;
    popped = 0;
    do_reset();
    for (int t = 0; t < NC + 10; t++) begin
      w = '0;
      row = '0;
      for (int c = 0; c < NC; c++) begin
        if (t - c >= 0 && t - c < NC) begin
          w[c] = 1'b1;
          row[c*BW +: BW] = 16'((t - c) * 16 + c);
        end
      end
      // A row read this cycle must be the next row in order.
      if (o_valid === 1'b1) begin
        for (int c = 0; c < NC; c++) begin
          checks++;
          if (dout[c*BW +: BW] !== 16'(popped * 16 + c)) begin
            errors++;
            $display("FAIL stream_order row=%0d lane=%0d: got=%h required=%h",
                     popped, c, dout[c*BW +: BW], 16'(popped * 16 + c));
          end
        end
        popped++;
      end
      cycle(w, row, 1'b1);
      checks++;
      if ({o_valid, o_full, o_ready, o_overflow} !== exp_st() || dout !== exp_out()) begin
        errors++;
        $display("FAIL stream_model t=%0d: status=%b out=%h required status=%b out=%h",
                 t, {o_valid, o_full, o_ready, o_overflow}, dout, exp_st(), exp_out());
      end
    end
    checks++;
    if (popped != NC) begin
      errors++;
      $display("FAIL stream_count: got=%0d required=%0d", popped, NC);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEP + 1; i++) begin
      cycle(NC'(8), rand_row(), 1'b0);
      checks++;
      if ({o_valid, o_full, o_ready, o_overflow} !== exp_st()) begin
        errors++;
        $display("FAIL full_model i=%0d: status=%b required=%b",
                 i, {o_valid, o_full, o_ready, o_overflow}, exp_st());
      end
      if (i == DEP - 1) begin
        checks++;
        if ({o_full, o_ready, o_overflow} !== 3'b100) begin
          errors++;
          $display("FAIL full_at_depth: full/ready/ovf=%b required=100", {o_full, o_ready, o_overflow});
        end
      end
    end
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got=%b required=1", o_overflow);
    end
    for (int i = 0; i < DEP; i++) cycle(NC'(8'hF7), rand_row(), 1'b0);
    for (int i = 0; i < DEP; i++) begin
      cycle('0, '0, 1'b1);
      checks++;
      if (dout !== exp_out() || {o_valid, o_full, o_ready, o_overflow} !== exp_st()) begin
        errors++;
        $display("FAIL drain_model i=%0d: status=%b out=%h required status=%b out=%h",
                 i, {o_valid, o_full, o_ready, o_overflow}, dout, exp_st(), exp_out());
      end
    end
    checks++;
    if ({o_valid, o_full, o_overflow} !== 3'b001) begin
      errors++;
      $display("FAIL overflow_sticky: valid/full/ovf=%b required=001", {o_valid, o_full, o_overflow});
    end
  endtask

  task automatic test_wrap();
    int rows_in, rows_out, t;
    logic r;
    logic [NC-1:0] w;
    rows_in = 0;
    rows_out = 0;
    t = 0;
    do_reset();
    while ((rows_in < 200 || exp_valid()) && t < 3000) begin
      w = (rows_in < 200 && !exp_full()) ? '1 : '0;
      r = ($urandom_range(0, 9) < 7);
      if (w[0]) rows_in++;
      if (r && exp_valid()) rows_out++;
      cycle(w, rand_row(), r);
      t++;
      checks++;
      if ({o_valid, o_full, o_ready, o_overflow} !== exp_st() || dout !== exp_out()) begin
        errors++;
        $display("FAIL wrap_model t=%0d: status=%b out=%h required status=%b out=%h",
                 t, {o_valid, o_full, o_ready, o_overflow}, dout, exp_st(), exp_out());
      end
    end
    checks++;
    if (rows_out != 200 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_total: rows=%0d ovf=%b required rows=200 ovf=0", rows_out, o_overflow);
    end
  endtask

  task automatic test_simul_rw();
    logic [NC*BW-1:0] a, b;
    do_reset();
    a = rand_row();
    b = rand_row();
    cycle('1, a, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || dout !== a) begin
      errors++;
      $display("FAIL rw_first: valid=%b out=%h required valid=1 out=%h", o_valid, dout, a);
    end
    cycle('1, b, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || dout !== b) begin
      errors++;
      $display("FAIL rw_same_cycle: valid=%b out=%h required valid=1 out=%h", o_valid, dout, b);
    end
    cycle('0, '0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL rw_count_one: valid=%b out=%h required valid=0 out=0", o_valid, dout);
    end
  endtask

  initial begin
    test_reset();
    test_skewed_fill();
    test_streaming();
    test_full_overflow();
    test_wrap();
    test_simul_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO stage directly downstream of the systolic MAC array. It captures the per-column partial sums that leave the bottom row of the array, each column on its own `valid` strobe, and buffers them in one FIFO per column. The columns are skewed in time, so this block re-aligns them: a full output row is presented to the consumer (SFU / output SRAM writer) only when every column holds at least one word.

## Interface
Parameters:
- `col`, 8, number of array columns, each with its own FIFO lane.
- `psum_bw`, 16, width of one partial-sum word.
- `depth`, 64, entries per column FIFO; must be a power of two and ≥ 2.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `in`, in, `psum_bw*col`, column c's psum occupies bits `[psum_bw*(c+1)-1 : psum_bw*c]`; connects to the array `out_s`.
- `wr`, in, `col`, per-column write strobe; connects to the array `valid`.
- `rd`, in, 1, pops one word from every column simultaneously.
- `out`, out, `psum_bw*col`, head words of all columns, using the same lane packing as `in`.
- `o_valid`, out, 1, high when every column FIFO is non-empty.
- `o_full`, out, 1, high when any column FIFO is full.
- `o_ready`, out, 1, equal to `~o_full`; upstream may issue array execute instructions only while it is high.
- `o_overflow`, out, 1, sticky flag; set when a write is dropped.

## Operation
- Each column has an independent write pointer, a read pointer, and an occupancy count.
  - Pointers are `log2(depth)` bits wide and wrap naturally from `depth-1` to 0.
  - The count is `log2(depth)+1` bits wide.
- Write, column c:
  - When `wr[c]=1` and column c is not full, store `in` lane c at `wr_ptr[c]`, then increment `wr_ptr[c]` and `count[c]`.
  - When `wr[c]=1` and column c is full, drop the word, leave the state unchanged, and set `o_overflow`.
  - A full column refuses a write even if a read pops it in the same cycle.
- Read:
  - When `rd=1` and `o_valid=1`, increment every column's `rd_ptr` and decrement its count.
  - When `rd=1` and `o_valid=0`, ignore the read: no pointer moves and no flag is set.
- Simultaneous write and read on a non-full, non-empty column: both take effect and the count is unchanged.
- Columns are written at different cycles because of the array skew. No column waits for another on the write side; re-alignment happens only on the read side through `o_valid`.
- `out` is first-word-fall-through: it shows `mem[c][rd_ptr[c]]` for every lane while `o_valid=1`, and it is all zeros while `o_valid=0`.
- Flags are combinational from the counts:
  - `o_valid` = AND over c of (`count[c] != 0`).
  - `o_full` = OR over c of (`count[c] == depth`).
- `o_overflow` is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous release by clock edge):
  - Clears all pointers and counts, and `o_overflow`.
  - Resulting outputs: `o_valid=0`, `o_full=0`, `o_ready=1`, `o_overflow=0`, `out=0`.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all buffered data immediately, without waiting for a clock edge.
- Write-to-visible latency is 1 cycle. A word written at edge t makes `count` non-zero after t. If that was the last empty column, `o_valid` rises in the cycle after edge t, and `out` holds valid data in that same cycle.
- On a read accepted at edge t, `out` advances to the next row after t. If any column becomes empty, `o_valid` falls after t.
- Back-to-back reads every cycle are supported: at most one row per cycle.
- `o_full` asserts in the cycle after the write that fills a column. It deasserts in the cycle after a read that frees the column.
- There are no registered outputs other than the state; all flags are combinational decodes of registers.

## Structure
- The shared package holds:
  - the default constants `COL=8`, `PSUM_BW=16`, `OFIFO_DEPTH=64`;
  - a derived `OFIFO_PTR_W = $clog2(OFIFO_DEPTH)`.
- Sub-module `ofifo_lane` is one single-column FWFT FIFO.
  - Ports: `clk`, `reset`, `wr`, `din`, `rd`, `dout`, `empty`, `full`, `overflow`.
  - `ofifo` instantiates `col` lanes in a generate loop and builds the flag AND/OR trees.
- The lane `rd` input is `rd & o_valid`, so every lane sees the identical qualified pop.

## Test plan
- Reset check: assert `reset=0` mid-stream with 5 rows buffered; release it. Required: `o_valid=0`, `o_full=0`, `o_overflow=0`, `out=0` with no clock edge needed while reset is held, and the old data is never read back.
- Skewed fill: write column c with value `0x0100+c` at cycle c, for c = 0..7. Required: `o_valid` stays 0 through cycle 7 and rises in cycle 8. `out` lane c then equals `0x0100+c`.
- Streaming: 8 skewed rows (row r, lane c = `r*16+c`) with `rd` held at 1. Required: the rows appear in order 0..7, one per cycle once aligned. Reads while `o_valid=0` cause no pointer movement.
- Full/overflow: write column 3 alone 64 times, then once more. Required: `o_full=1` and `o_ready=0` after the 64th write. The 65th write is dropped and sets `o_overflow=1`. The sticky flag holds after reads drain the FIFO.
- Wrap-around: run 200 rows at full rate with random read stalls at depth 64. Required: output order matches input order, and there is no overflow.
- Simultaneous read/write: with 1 row buffered, write the next row and read in the same cycle on all columns. Required: the counts stay at 1, and `out` shows the new row in the next cycle.
